// File: rtl/s1488_bist_pkg.sv
// Shared types and constants for the s1488 BIST sequencer.
// Holds the FSM state encoding, the core I/O widths, and the LFSR/MISR
// polynomials, plus small helpers for the LFSR.
package s1488_bist_pkg;

   localparam int unsigned PI_W   = 7;   // core primary inputs v0..v6
   localparam int unsigned PO_W   = 19;  // core outputs v13_D_6..v13_D_24
   localparam int unsigned CNT_W  = 16;  // pattern counter width
   localparam int unsigned RCNT_W = 4;   // core-reset cycle counter width

   // x^7 + x^6 + 1: feedback is the XOR of bits 6 and 5
   localparam logic [PI_W-1:0] LFSR_TAPS = 7'h60;

   // x^19 + x^5 + x^2 + x + 1 (the x^19 term is the shifted-out MSB)
   localparam logic [PO_W-1:0] MISR_POLY = 19'h00027;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET_CUT,
      ST_RUN,
      ST_COMPARE,
      ST_DONE
   } bist_state_e;

   // One LFSR shift: left shift with the tap parity fed into bit 0
   function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] l);
      return {l[PI_W-2:0], ^(l & LFSR_TAPS)};
   endfunction

   // An all-zero LFSR would lock up, so a zero seed becomes 1
   function automatic logic [PI_W-1:0] lfsr_seed_fix(input logic [PI_W-1:0] s);
      return (s == '0) ? PI_W'(1) : s;
   endfunction

endpackage

// File: rtl/s1488_bist_ctrl_if.sv
// Bus between system logic, the BIST sequencer and the s1488 core.
// master: system side (drives start/abort/func_pi/golden_sig, and the core
//         drives cut_po); slave: the BIST sequencer.
//   start, abort  : run control levels
//   func_pi       : functional values for v0..v6
//   golden_sig    : expected signature, sampled in COMPARE
//   cut_po        : core outputs {v13_D_24..v13_D_6}
//   cut_pi        : core inputs v0..v6
//   cut_rst_n     : active-low reset to the core flops
//   busy/done/pass, signature, pattern_cnt : status
interface s1488_bist_ctrl_if;
   import s1488_bist_pkg::*;

   logic              start;
   logic              abort;
   logic [PI_W-1:0]   func_pi;
   logic [PO_W-1:0]   golden_sig;
   logic [PO_W-1:0]   cut_po;
   logic [PI_W-1:0]   cut_pi;
   logic              cut_rst_n;
   logic              busy;
   logic              done;
   logic              pass;
   logic [PO_W-1:0]   signature;
   logic [CNT_W-1:0]  pattern_cnt;

   modport master (
      output start, abort, func_pi, golden_sig, cut_po,
      input  cut_pi, cut_rst_n, busy, done, pass, signature, pattern_cnt
   );

   modport slave (
      input  start, abort, func_pi, golden_sig, cut_po,
      output cut_pi, cut_rst_n, busy, done, pass, signature, pattern_cnt
   );

endinterface

// File: rtl/s1488_misr.sv
// 19-bit multiple-input signature register for compacting core outputs.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   load       : reload SEED (wins over en)
//   en         : shift with feedback and fold in data_in
//   data_in    : parallel core outputs
//   sig        : current signature
module s1488_misr
   import s1488_bist_pkg::*;
#(
   parameter logic [PO_W-1:0] SEED = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            en,
   input  logic [PO_W-1:0] data_in,
   output logic [PO_W-1:0] sig
);

   // Signature update; holds when neither load nor en is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= SEED;
      end else if (load) begin
         sig <= SEED;
      end else if (en) begin
         sig <= {sig[PO_W-2:0], 1'b0}
              ^ (sig[PO_W-1] ? MISR_POLY : '0)
              ^ data_in;
      end
   end

endmodule

// File: rtl/s1488_bist_ctrl.sv
// BIST sequencer for the s1488 core. Passes func_pi through in IDLE/DONE;
// on start it resets the core, applies NUM_PATTERNS LFSR vectors, compacts
// the core outputs in a MISR and compares against golden_sig.
//   CK   : clock, rising edge
//   CLR  : async active-low reset
//   bus  : s1488_bist_ctrl_if slave (control, core I/O and status)
module s1488_bist_ctrl
   import s1488_bist_pkg::*;
#(
   parameter int unsigned      NUM_PATTERNS = 1024,
   parameter int unsigned      RESET_CYCLES = 2,
   parameter logic [PI_W-1:0]  LFSR_SEED    = 7'h01,
   parameter logic [PO_W-1:0]  MISR_SEED    = '0
) (
   input  logic              CK,
   input  logic              CLR,
   s1488_bist_ctrl_if.slave  bus
);

   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_PATTERNS);
   localparam logic [PI_W-1:0]   LFSR_INIT = lfsr_seed_fix(LFSR_SEED);

   bist_state_e        state_q, state_d;
   logic [PI_W-1:0]    lfsr_q;
   logic [RCNT_W-1:0]  rcnt_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic               cut_rst_n_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic               start_run;
   logic               run_step;
   logic [PO_W-1:0]    sig;

   assign cnt_inc  = cnt_q + CNT_W'(1);
   // A vector applied in RUN is counted and compacted even on an abort edge
   assign run_step = (state_q == ST_RUN);

   // Next-state logic; abort overrides every transition including start
   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d   = ST_RESET_CUT;
               start_run = 1'b1;
            end
         end
         ST_RESET_CUT: begin
            if (rcnt_q == RCNT_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cnt_inc == CNT_LAST) state_d = ST_COMPARE;
         end
         ST_COMPARE: state_d = ST_DONE;
         default:    state_d = ST_IDLE;
      endcase
      if (bus.abort) begin
         state_d   = ST_IDLE;
         start_run = 1'b0;
      end
   end

   // State register
   always_ff @(posedge CK or negedge CLR) begin
      if (!CLR) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Datapath registers and registered status outputs
   always_ff @(posedge CK or negedge CLR) begin
      if (!CLR) begin
         lfsr_q      <= LFSR_INIT;
         rcnt_q      <= '0;
         cnt_q       <= '0;
         cut_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         if (start_run)     lfsr_q <= LFSR_INIT;
         else if (run_step) lfsr_q <= lfsr_next(lfsr_q);

         if (start_run)                    rcnt_q <= '0;
         else if (state_q == ST_RESET_CUT) rcnt_q <= rcnt_q + RCNT_W'(1);

         if (start_run)     cnt_q <= '0;
         else if (run_step) cnt_q <= cnt_inc;

         if (bus.abort || start_run)     pass_q <= 1'b0;
         else if (state_q == ST_COMPARE) pass_q <= (sig == bus.golden_sig);

         // Decoded from the next state so they line up with state_q
         cut_rst_n_q <= (state_d != ST_RESET_CUT);
         busy_q      <= (state_d == ST_RESET_CUT) || (state_d == ST_RUN)
                     || (state_d == ST_COMPARE);
         done_q      <= (state_d == ST_DONE);
      end
   end

   s1488_misr #(
      .SEED    (MISR_SEED)
   ) u_misr (
      .clk     (CK),
      .rst_n   (CLR),
      .load    (start_run),
      .en      (run_step),
      .data_in (bus.cut_po),
      .sig     (sig)
   );

   // Core input mux: select only changes with the registered state
   always_comb begin
      case (state_q)
         ST_IDLE, ST_DONE: bus.cut_pi = bus.func_pi;
         ST_RUN:           bus.cut_pi = lfsr_q;
         default:          bus.cut_pi = '0;
      endcase
   end

   assign bus.cut_rst_n   = cut_rst_n_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.signature   = sig;
   assign bus.pattern_cnt = cnt_q;

endmodule

// File: tb/tb_s1488_bist_ctrl.sv
// Bench for s1488_bist_ctrl: two instances (long and short run), a fake
// combinational core, a reference model and done-triggered scoreboards.
module tb_s1488_bist_ctrl;
   import s1488_bist_pkg::*;

   localparam int unsigned NA = 7;
   localparam int unsigned RA = 2;
   localparam int unsigned NB = 2;
   localparam int unsigned RB = 1;
   localparam logic [6:0]  SEED_A = 7'h01;
   localparam logic [6:0]  SEED_B = 7'h00;

   typedef struct {
      logic [18:0] sig;
      logic        pass;
      logic [15:0] cnt;
      int unsigned done_cyc;
   } exp_t;

   logic        CK = 1'b0;
   logic        CLR;
   logic [18:0] core_key;
   logic [18:0] po_b;
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   logic        done_a_prev = 1'b0;
   logic        done_b_prev = 1'b0;

   always #5 CK = ~CK;
   always @(posedge CK) cyc <= cyc + 1;

   s1488_bist_ctrl_if ifa();
   s1488_bist_ctrl_if ifb();

   s1488_bist_ctrl #(.NUM_PATTERNS(NA), .RESET_CYCLES(RA),
                     .LFSR_SEED(SEED_A), .MISR_SEED(19'h00000))
      dut_a (.CK(CK), .CLR(CLR), .bus(ifa));

   s1488_bist_ctrl #(.NUM_PATTERNS(NB), .RESET_CYCLES(RB),
                     .LFSR_SEED(SEED_B), .MISR_SEED(19'h00000))
      dut_b (.CK(CK), .CLR(CLR), .bus(ifb));

   // Stand-in for the core: an arbitrary keyed function of its inputs
   function automatic logic [18:0] fake_core(logic [6:0] pi, logic [18:0] key);
      logic [18:0] p;
      p = 19'(pi) * 19'h03579;
      return p ^ key ^ {pi, pi[4:0], pi};
   endfunction

   assign ifa.cut_po = fake_core(ifa.cut_pi, core_key);
   assign ifb.cut_po = po_b;

   // LFSR value after n steps, as plain integer arithmetic
   function automatic int unsigned m_lfsr(int unsigned seed, int unsigned n);
      int unsigned l;
      l = (seed == 0) ? 1 : seed;
      for (int i = 0; i < int'(n); i++)
         l = ((l << 1) | (((l >> 6) ^ (l >> 5)) & 1)) & 127;
      return l;
   endfunction

   // Signature after n vectors: polynomial doubling mod p(x), plus response
   function automatic logic [18:0] m_sig(int unsigned seed_l, int unsigned n,
                                         bit const_po, logic [18:0] po_c,
                                         logic [18:0] key);
      int unsigned m;
      int unsigned po;
      m = 0;
      for (int i = 0; i < int'(n); i++) begin
         po = const_po ? 32'(po_c) : 32'(fake_core(7'(m_lfsr(seed_l, i)), key));
         m  = m << 1;
         if ((m & 32'h80000) != 0) m = m ^ 32'h80027;
         m = m ^ po;
      end
      return 19'(m);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic drain(input bit use_b);
      for (int i = 0; i < 200; i++) begin
         if ((use_b ? qb.size() : qa.size()) == 0) return;
         @(negedge CK);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0",
               use_b ? qb.size() : qa.size());
   endtask

   function automatic logic [18:0] pick_golden(logic [18:0] sig);
      if ($urandom_range(0, 1) == 1) return sig;
      return sig ^ 19'(19'h1 << $urandom_range(0, 18));
   endfunction

   // Queue the expected outcome of a run on dut_a started at edge k
   task automatic push_a(int unsigned k);
      exp_t e;
      e.sig      = m_sig(32'(SEED_A), NA, 1'b0, 19'h0, core_key);
      e.pass     = (ifa.golden_sig == e.sig);
      e.cnt      = 16'(NA);
      e.done_cyc = k + RA + NA + 1;
      qa.push_back(e);
   endtask

   task automatic push_b(int unsigned k);
      exp_t e;
      e.sig      = m_sig(32'(SEED_B), NB, 1'b1, po_b, 19'h0);
      e.pass     = (ifb.golden_sig == e.sig);
      e.cnt      = 16'(NB);
      e.done_cyc = k + RB + NB + 1;
      qb.push_back(e);
   endtask

   // Scoreboard monitors: compare on each rising done
   always @(negedge CK) begin
      if (CLR === 1'b1 && ifa.done === 1'b1 && !done_a_prev) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_done: done rose at cycle %0d with no run pending", cyc);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_signature", 32'(ifa.signature), 32'(e.sig));
            chk("a_pass", 32'(ifa.pass), 32'(e.pass));
            chk("a_pattern_cnt", 32'(ifa.pattern_cnt), 32'(e.cnt));
            chk("a_done_latency", cyc, e.done_cyc);
         end
      end
      done_a_prev = ifa.done;
   end

   always @(negedge CK) begin
      if (CLR === 1'b1 && ifb.done === 1'b1 && !done_b_prev) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_done: done rose at cycle %0d with no run pending", cyc);
         end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_signature", 32'(ifb.signature), 32'(e.sig));
            chk("b_pass", 32'(ifb.pass), 32'(e.pass));
            chk("b_pattern_cnt", 32'(ifb.pattern_cnt), 32'(e.cnt));
            chk("b_done_latency", cyc, e.done_cyc);
         end
      end
      done_b_prev = ifb.done;
   end

   initial begin
      int unsigned k;
      logic [18:0] s;
      CLR = 1'b0;
      core_key = 19'($urandom);
      po_b = 19'h00001;
      ifa.start = 1'b0; ifa.abort = 1'b0; ifa.func_pi = '0; ifa.golden_sig = '0;
      ifb.start = 1'b0; ifb.abort = 1'b0; ifb.func_pi = '0; ifb.golden_sig = '0;

      // Reset values while CLR is held
      #2;
      chk("rst_cut_rst_n", 32'(ifa.cut_rst_n), 0);
      chk("rst_busy", 32'(ifa.busy), 0);
      chk("rst_done", 32'(ifa.done), 0);
      chk("rst_pass", 32'(ifa.pass), 0);
      chk("rst_signature", 32'(ifa.signature), 0);
      chk("rst_pattern_cnt", 32'(ifa.pattern_cnt), 0);
      #10 CLR = 1'b1;
      tick();
      chk("rel_cut_rst_n", 32'(ifa.cut_rst_n), 1);

      // Functional passthrough in IDLE
      ifa.func_pi = 7'h55;
      #1 chk("idle_passthru_55", 32'(ifa.cut_pi), 32'h55);
      for (int i = 0; i < 3; i++) begin
         ifa.func_pi = 7'($urandom);
         #1 chk("idle_passthru_rand", 32'(ifa.cut_pi), 32'(ifa.func_pi));
      end

      // First run with cycle-by-cycle checks of the core interface
      core_key = 19'($urandom);
      ifa.golden_sig = pick_golden(m_sig(32'(SEED_A), NA, 1'b0, 19'h0, core_key));
      ifa.start = 1'b1;
      k = cyc + 1;
      push_a(k);
      tick();
      ifa.start = 1'b0;
      ifa.func_pi = 7'($urandom);
      chk("busy_after_start", 32'(ifa.busy), 1);
      for (int i = 0; i < int'(RA); i++) begin
         chk("rc_cut_rst_n", 32'(ifa.cut_rst_n), 0);
         chk("rc_cut_pi", 32'(ifa.cut_pi), 0);
         tick();
      end
      for (int i = 0; i < int'(NA); i++) begin
         chk("run_cut_pi", 32'(ifa.cut_pi), m_lfsr(32'(SEED_A), i));
         chk("run_cut_rst_n", 32'(ifa.cut_rst_n), 1);
         chk("run_pattern_cnt", 32'(ifa.pattern_cnt), i);
         ifa.func_pi = 7'($urandom);
         tick();
      end
      drain(1'b0);
      ifa.func_pi = 7'($urandom);
      #1 chk("done_passthru", 32'(ifa.cut_pi), 32'(ifa.func_pi));

      // Randomized back-to-back runs
      for (int r = 0; r < 6; r++) begin
         core_key = 19'($urandom);
         ifa.golden_sig = pick_golden(m_sig(32'(SEED_A), NA, 1'b0, 19'h0, core_key));
         ifa.start = 1'b1;
         k = cyc + 1;
         push_a(k);
         tick();
         ifa.start = 1'b0;
         drain(1'b0);
      end

      // CLR pulse between edges while in DONE
      @(negedge CK);
      #2 CLR = 1'b0;
      #1;
      chk("clr_signature", 32'(ifa.signature), 0);
      chk("clr_cut_rst_n", 32'(ifa.cut_rst_n), 0);
      chk("clr_done", 32'(ifa.done), 0);
      chk("clr_pattern_cnt", 32'(ifa.pattern_cnt), 0);
      #1 CLR = 1'b1;
      tick();
      chk("clr_rel_cut_rst_n", 32'(ifa.cut_rst_n), 1);
      chk("clr_rel_busy", 32'(ifa.busy), 0);

      // CLR in the middle of RUN
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      repeat (RA + 2) tick();
      #2 CLR = 1'b0;
      #1;
      chk("midrun_clr_busy", 32'(ifa.busy), 0);
      chk("midrun_clr_cut_rst_n", 32'(ifa.cut_rst_n), 0);
      chk("midrun_clr_cnt", 32'(ifa.pattern_cnt), 0);
      #1 CLR = 1'b1;
      tick();

      // Abort on the 3rd RUN cycle, with start asserted alongside
      core_key = 19'($urandom);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      repeat (RA + 2) tick();
      ifa.abort = 1'b1;
      ifa.start = 1'b1;
      tick();
      chk("abort_busy", 32'(ifa.busy), 0);
      chk("abort_done", 32'(ifa.done), 0);
      chk("abort_pattern_cnt", 32'(ifa.pattern_cnt), 3);
      chk("abort_cut_rst_n", 32'(ifa.cut_rst_n), 1);
      chk("abort_signature", 32'(ifa.signature),
          32'(m_sig(32'(SEED_A), 3, 1'b0, 19'h0, core_key)));
      tick();
      chk("abort_start_ignored", 32'(ifa.busy), 0);
      chk("abort_cnt_held", 32'(ifa.pattern_cnt), 3);
      ifa.abort = 1'b0;
      ifa.start = 1'b0;
      tick();

      // start held through DONE restarts immediately
      core_key = 19'($urandom);
      ifa.golden_sig = pick_golden(m_sig(32'(SEED_A), NA, 1'b0, 19'h0, core_key));
      ifa.start = 1'b1;
      k = cyc + 1;
      push_a(k);
      push_a(k + RA + NA + 2);
      tick();
      repeat (RA + NA + 1) tick();
      chk("hold_done", 32'(ifa.done), 1);
      tick();
      chk("restart_busy", 32'(ifa.busy), 1);
      chk("restart_done", 32'(ifa.done), 0);
      chk("restart_cnt", 32'(ifa.pattern_cnt), 0);
      chk("restart_signature", 32'(ifa.signature), 0);
      chk("restart_cut_rst_n", 32'(ifa.cut_rst_n), 0);
      ifa.start = 1'b0;
      drain(1'b0);

      // abort from DONE
      ifa.abort = 1'b1;
      tick();
      chk("done_abort_done", 32'(ifa.done), 0);
      chk("done_abort_busy", 32'(ifa.busy), 0);
      ifa.abort = 1'b0;

      // Short instance: constant response, zero LFSR seed, one reset cycle
      for (int r = 0; r < 6; r++) begin
         if (r < 2) po_b = 19'h00001;
         else       po_b = 19'($urandom);
         s = m_sig(32'(SEED_B), NB, 1'b1, po_b, 19'h0);
         if (r == 0)      ifb.golden_sig = 19'h00003;
         else if (r == 1) ifb.golden_sig = 19'h00002;
         else             ifb.golden_sig = pick_golden(s);
         ifb.start = 1'b1;
         k = cyc + 1;
         push_b(k);
         tick();
         ifb.start = 1'b0;
         chk("b_rc_cut_pi", 32'(ifb.cut_pi), 0);
         tick();
         chk("b_run_cut_pi0", 32'(ifb.cut_pi), 32'h01);
         tick();
         chk("b_run_cut_pi1", 32'(ifb.cut_pi), 32'h02);
         drain(1'b1);
         if (r == 0) chk("b_const_sig", 32'(ifb.signature), 32'h00003);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, %0d errors so far", errors);
      $fatal(1, "timeout");
   end

endmodule
